// File: rtl/wb_arb.sv
// Writeback arbiter: round-robin selection among NCH result channels, drives
// the register-file write port, retire and trap pulses, a flush window after
// each trap, and a 64-bit retired-instruction counter.
module wb_arb #(
  parameter int XLEN          = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int PC_WIDTH      = 32,
  parameter int NCH           = 3,
  parameter int FLUSH_CYC     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NCH-1:0]               ch_vld_i,
  output logic [NCH-1:0]               ch_rdy_o,
  input  logic [NCH-1:0]               ch_rd_en_i,
  input  logic [NCH*REG_IDX_WIDTH-1:0] ch_rd_idx_i,
  input  logic [NCH*XLEN-1:0]          ch_rd_wdata_i,
  input  logic [NCH*PC_WIDTH-1:0]      ch_pc_i,
  input  logic [NCH-1:0]               ch_excp_i,
  input  logic [NCH*4-1:0]             ch_cause_i,
  output logic                         wb_rd_en_o,
  output logic [REG_IDX_WIDTH-1:0]     wb_rd_idx_o,
  output logic [XLEN-1:0]              wb_rd_wdata_o,
  output logic                         retire_vld_o,
  output logic [PC_WIDTH-1:0]          retire_pc_o,
  output logic                         trap_vld_o,
  output logic [3:0]                   trap_cause_o,
  output logic [PC_WIDTH-1:0]          trap_epc_o,
  output logic                         flush_o,
  output logic [63:0]                  instret_o
);

  localparam int PTR_W = $clog2(NCH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                   state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [3:0]               flush_cnt;

  logic [NCH-1:0]           gnt;
  logic                     gnt_found;
  logic [PTR_W-1:0]         gnt_idx;
  logic [PTR_W-1:0]         nxt_ptr;
  logic                     sel_excp;
  logic                     sel_rd_en;
  logic [REG_IDX_WIDTH-1:0] sel_rd_idx;
  logic [XLEN-1:0]          sel_rd_wdata;
  logic [PC_WIDTH-1:0]      sel_pc;
  logic [3:0]               sel_cause;

  // Round-robin search: first valid channel at or after rr_ptr, wrapping.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < int'(NCH); i++) begin
      int unsigned      cand;
      logic [PTR_W-1:0] cand_idx;
      cand     = (int'(rr_ptr) + i) % int'(NCH);
      cand_idx = PTR_W'(cand);
      if (!gnt_found && ch_vld_i[cand_idx]) begin
        gnt_found     = 1'b1;
        gnt_idx       = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

  // Mux the granted channel's fields out of the packed input buses.
  always_comb begin
    sel_rd_idx   = '0;
    sel_rd_wdata = '0;
    sel_pc       = '0;
    sel_cause    = '0;
    for (int unsigned k = 0; k < int'(NCH); k++) begin
      if (gnt[k]) begin
        sel_rd_idx   = ch_rd_idx_i[k*REG_IDX_WIDTH +: REG_IDX_WIDTH];
        sel_rd_wdata = ch_rd_wdata_i[k*XLEN +: XLEN];
        sel_pc       = ch_pc_i[k*PC_WIDTH +: PC_WIDTH];
        sel_cause    = ch_cause_i[k*4 +: 4];
      end
    end
  end

  // Handshake qualifiers and the pointer value following the granted channel.
  always_comb begin
    sel_excp  = |(gnt & ch_excp_i);
    sel_rd_en = |(gnt & ch_rd_en_i);
    nxt_ptr   = (gnt_idx == PTR_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Ready: one-hot grant in RUN, drain everything in FLUSH; forced low in reset
  // so no channel can see a handshake while rst_n is asserted.
  always_comb begin
    if (!rst_n) begin
      ch_rdy_o = '0;
    end else if (state == FLUSH) begin
      ch_rdy_o = '1;
    end else begin
      ch_rdy_o = gnt;
    end
  end

  // State, pointer, flush counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      rr_ptr        <= '0;
      flush_cnt     <= '0;
      wb_rd_en_o    <= 1'b0;
      wb_rd_idx_o   <= '0;
      wb_rd_wdata_o <= '0;
      retire_vld_o  <= 1'b0;
      retire_pc_o   <= '0;
      trap_vld_o    <= 1'b0;
      trap_cause_o  <= '0;
      trap_epc_o    <= '0;
      flush_o       <= 1'b0;
      instret_o     <= '0;
    end else begin
      wb_rd_en_o   <= 1'b0;
      retire_vld_o <= 1'b0;
      trap_vld_o   <= 1'b0;
      case (state)
        RUN: begin
          if (gnt_found) begin
            rr_ptr <= nxt_ptr;
            if (sel_excp) begin
              trap_vld_o   <= 1'b1;
              trap_cause_o <= sel_cause;
              trap_epc_o   <= sel_pc;
              state        <= FLUSH;
              flush_cnt    <= 4'(FLUSH_CYC);
              flush_o      <= 1'b1;
            end else begin
              retire_vld_o <= 1'b1;
              retire_pc_o  <= sel_pc;
              instret_o    <= instret_o + 64'd1;
              if (sel_rd_en && (sel_rd_idx != '0)) begin
                wb_rd_en_o    <= 1'b1;
                wb_rd_idx_o   <= sel_rd_idx;
                wb_rd_wdata_o <= sel_rd_wdata;
              end
            end
          end
        end
        FLUSH: begin
          rr_ptr <= '0;
          if (flush_cnt <= 4'd1) begin
            state     <= RUN;
            flush_cnt <= '0;
            flush_o   <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arb.sv
// Directed and randomized checks of wb_arb against a behavioural model.
module tb_wb_arb;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int PCW  = 32;
  localparam int NCH  = 3;
  localparam int FC   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       ch_vld_i;
  logic [NCH-1:0]       ch_rdy_o;
  logic [NCH-1:0]       ch_rd_en_i;
  logic [NCH*RW-1:0]    ch_rd_idx_i;
  logic [NCH*XLEN-1:0]  ch_rd_wdata_i;
  logic [NCH*PCW-1:0]   ch_pc_i;
  logic [NCH-1:0]       ch_excp_i;
  logic [NCH*4-1:0]     ch_cause_i;
  logic                 wb_rd_en_o;
  logic [RW-1:0]        wb_rd_idx_o;
  logic [XLEN-1:0]      wb_rd_wdata_o;
  logic                 retire_vld_o;
  logic [PCW-1:0]       retire_pc_o;
  logic                 trap_vld_o;
  logic [3:0]           trap_cause_o;
  logic [PCW-1:0]       trap_epc_o;
  logic                 flush_o;
  logic [63:0]          instret_o;

  always #5 clk = ~clk;

  wb_arb #(
    .XLEN(XLEN), .REG_IDX_WIDTH(RW), .PC_WIDTH(PCW), .NCH(NCH), .FLUSH_CYC(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_vld_i(ch_vld_i), .ch_rdy_o(ch_rdy_o), .ch_rd_en_i(ch_rd_en_i),
    .ch_rd_idx_i(ch_rd_idx_i), .ch_rd_wdata_i(ch_rd_wdata_i), .ch_pc_i(ch_pc_i),
    .ch_excp_i(ch_excp_i), .ch_cause_i(ch_cause_i),
    .wb_rd_en_o(wb_rd_en_o), .wb_rd_idx_o(wb_rd_idx_o), .wb_rd_wdata_o(wb_rd_wdata_o),
    .retire_vld_o(retire_vld_o), .retire_pc_o(retire_pc_o),
    .trap_vld_o(trap_vld_o), .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o),
    .flush_o(flush_o), .instret_o(instret_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: next channel to look at, flush cycles remaining,
  // and the values each registered output should hold.
  int                m_ptr;
  int                m_flush;
  longint unsigned   m_instret;
  logic              m_wb_en;
  logic [RW-1:0]     m_wb_idx;
  logic [XLEN-1:0]   m_wb_data;
  logic              m_ret_vld;
  logic [PCW-1:0]    m_ret_pc;
  logic              m_trap_vld;
  logic [3:0]        m_trap_cause;
  logic [PCW-1:0]    m_trap_epc;
  logic              m_flush_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_flush = 0; m_instret = 0;
    m_wb_en = 0; m_wb_idx = '0; m_wb_data = '0;
    m_ret_vld = 0; m_ret_pc = '0;
    m_trap_vld = 0; m_trap_cause = '0; m_trap_epc = '0;
    m_flush_o = 0;
  endtask

  // Channel the model would accept this cycle, or -1.
  function automatic int pick();
    int c;
    if (m_flush > 0) return -1;
    for (int i = 0; i < NCH; i++) begin
      c = (m_ptr + i) % NCH;
      if (ch_vld_i[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] exp_rdy();
    logic [NCH-1:0] r;
    int k;
    r = '0;
    if (m_flush > 0) return '1;
    k = pick();
    if (k >= 0) r[k] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int k;
    logic [RW-1:0] idx;
    k = pick();
    m_wb_en = 0; m_ret_vld = 0; m_trap_vld = 0;
    if (m_flush > 0) begin
      m_flush--;
      m_ptr = 0;
    end else if (k >= 0) begin
      m_ptr = (k + 1) % NCH;
      if (ch_excp_i[k]) begin
        m_trap_vld   = 1;
        m_trap_cause = ch_cause_i[k*4 +: 4];
        m_trap_epc   = ch_pc_i[k*PCW +: PCW];
        m_flush      = FC;
      end else begin
        m_ret_vld = 1;
        m_ret_pc  = ch_pc_i[k*PCW +: PCW];
        m_instret = m_instret + 1;
        idx = ch_rd_idx_i[k*RW +: RW];
        if (ch_rd_en_i[k] && idx != 0) begin
          m_wb_en   = 1;
          m_wb_idx  = idx;
          m_wb_data = ch_rd_wdata_i[k*XLEN +: XLEN];
        end
      end
    end
    m_flush_o = (m_flush > 0);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".wb_rd_en"},    wb_rd_en_o,    m_wb_en);
    chk({tag, ".wb_rd_idx"},   wb_rd_idx_o,   m_wb_idx);
    chk({tag, ".wb_rd_wdata"}, wb_rd_wdata_o, m_wb_data);
    chk({tag, ".retire_vld"},  retire_vld_o,  m_ret_vld);
    chk({tag, ".retire_pc"},   retire_pc_o,   m_ret_pc);
    chk({tag, ".trap_vld"},    trap_vld_o,    m_trap_vld);
    chk({tag, ".trap_cause"},  trap_cause_o,  m_trap_cause);
    chk({tag, ".trap_epc"},    trap_epc_o,    m_trap_epc);
    chk({tag, ".flush"},       flush_o,       m_flush_o);
    chk({tag, ".instret"},     instret_o,     m_instret);
  endtask

  // Called just after a falling edge with inputs applied: checks ready,
  // advances one clock, checks registered outputs, returns at next falling edge.
  task automatic step(input string tag);
    #1;
    chk({tag, ".ch_rdy"}, ch_rdy_o, exp_rdy());
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
    @(negedge clk);
  endtask

  task automatic clear_all();
    ch_vld_i = '0; ch_rd_en_i = '0; ch_rd_idx_i = '0; ch_rd_wdata_i = '0;
    ch_pc_i = '0; ch_excp_i = '0; ch_cause_i = '0;
  endtask

  task automatic set_ch(input int k, input logic v, input logic en, input logic [RW-1:0] idx,
                        input logic [XLEN-1:0] d, input logic [PCW-1:0] pc,
                        input logic ex, input logic [3:0] cause);
    ch_vld_i[k]                = v;
    ch_rd_en_i[k]              = en;
    ch_rd_idx_i[k*RW +: RW]    = idx;
    ch_rd_wdata_i[k*XLEN +: XLEN] = d;
    ch_pc_i[k*PCW +: PCW]      = pc;
    ch_excp_i[k]               = ex;
    ch_cause_i[k*4 +: 4]       = cause;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_all();
    model_reset();
    #2;
    check_outs("reset");
    chk("reset.ch_rdy", ch_rdy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with all channels valid
    for (int k = 0; k < NCH; k++)
      set_ch(k, 1, 1, RW'(k + 1), 32'h1000 + 32'(k), 32'h100 + 32'(4 * k), 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rr.grant", ch_rdy_o, 64'(1) << i);
      step("rr");
      chk("rr.wb_pulse", wb_rd_en_o, 1);
      chk("rr.wb_idx", wb_rd_idx_o, i + 1);
    end
    chk("rr.instret", instret_o, 3);

    // Write to x0 retires but does not write
    clear_all();
    set_ch(1, 1, 1, 0, 32'hDEADBEEF, 32'h200, 0, 0);
    step("x0");
    chk("x0.retire", retire_vld_o, 1);
    chk("x0.wb_en", wb_rd_en_o, 0);
    chk("x0.instret", instret_o, 4);

    // Exception on ch2 then two flush cycles with everything valid
    clear_all();
    set_ch(2, 1, 0, 0, 0, 32'h80000010, 1, 4'd2);
    step("excp");
    chk("excp.trap_vld", trap_vld_o, 1);
    chk("excp.cause", trap_cause_o, 2);
    chk("excp.epc", trap_epc_o, 32'h80000010);
    chk("excp.flush", flush_o, 1);
    for (int k = 0; k < NCH; k++)
      set_ch(k, 1, 1, 5'd7, 32'h55, 32'h300, 0, 0);
    for (int i = 0; i < FC; i++) begin
      #1;
      chk("flush.rdy", ch_rdy_o, 3'b111);
      step("flush");
      chk("flush.no_retire", retire_vld_o, 0);
    end
    chk("flush.done", flush_o, 0);
    chk("flush.instret", instret_o, 4);

    // Simultaneous normal (ch0) and exception (ch1) with pointer at 1
    clear_all();
    set_ch(0, 1, 1, 5'd3, 32'hA0, 32'h400, 0, 0);
    step("sim.pre");
    set_ch(1, 1, 1, 5'd4, 32'hB0, 32'h404, 1, 4'd5);
    #1;
    chk("sim.grant", ch_rdy_o, 3'b010);
    step("sim");
    chk("sim.trap", trap_vld_o, 1);
    chk("sim.cause", trap_cause_o, 5);
    set_ch(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < FC; i++) step("sim.flush");
    chk("sim.instret", instret_o, 5);
    clear_all();
    step("idle");
    chk("idle.retire", retire_vld_o, 0);

    // Reset asserted in the first flush cycle
    set_ch(0, 1, 0, 0, 0, 32'h500, 1, 4'd7);
    step("rstf.excp");
    chk("rstf.in_flush", flush_o, 1);
    clear_all();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("rstf.async");
    chk("rstf.ch_rdy", ch_rdy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ch(0, 1, 1, 5'd9, 32'hC0FFEE, 32'h600, 0, 0);
    step("rstf.after");
    chk("rstf.retire", retire_vld_o, 1);
    chk("rstf.flush", flush_o, 0);
    chk("rstf.instret", instret_o, 1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      clear_all();
      for (int k = 0; k < NCH; k++)
        set_ch(k, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? RW'(0) : RW'($urandom),
               32'($urandom), 32'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom));
      step("rand");
    end

    // instret wrap
    clear_all();
    while (flush_o) step("drain");
    force dut.instret_o = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_o;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    set_ch(0, 1, 1, 5'd1, 32'h1, 32'h700, 0, 0);
    step("wrap");
    chk("wrap.instret", instret_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
